// File: rtl/shifter_pipe_pkg.sv
// Shared op encodings and stage shamt-group helper for shifter_pipe.
package shifter_pipe_pkg;

    localparam logic [1:0] SH_OP_SLL = 2'b00;
    localparam logic [1:0] SH_OP_SRL = 2'b01;
    localparam logic [1:0] SH_OP_SRA = 2'b10;
    localparam logic [1:0] SH_OP_ROR = 2'b11;

    // Lowest shamt bit owned by a stage; earlier stages take the larger share.
    function automatic int grp_lo(input int idx, input int width, input int stages);
        int base;
        int rem;
        base = width / stages;
        rem  = width % stages;
        return idx * base + ((idx < rem) ? idx : rem);
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One shamt-bit-group shifter with its valid/data pipeline register.
// Rotate muxes exist only when SHIFTER_ROTATE_EN is defined.
module shifter_stage
    import shifter_pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5,
    parameter int LO      = 0,
    parameter int HI      = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               nxt,
    output logic               take,
    input  logic               in_valid,
    input  logic [1:0]         in_op,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_sign,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    output logic [1:0]         out_op,
    output logic [DATA_W-1:0]  out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic               out_sign,
    output logic [TAG_W-1:0]   out_tag
);

    localparam logic [DATA_W-1:0] ONES = '1;

    logic [DATA_W-1:0] shifted;

    function automatic logic [DATA_W-1:0] shift_by(
        input logic [DATA_W-1:0] x,
        input logic [1:0]        op,
        input logic              s,
        input int                k
    );
        logic [DATA_W-1:0] r;
        case (op)
            SH_OP_SLL: r = x << k;
            SH_OP_SRL: r = x >> k;
            SH_OP_SRA: r = (x >> k) | (s ? ~(ONES >> k) : '0);
`ifdef SHIFTER_ROTATE_EN
            SH_OP_ROR: r = (x >> k) | (x << (DATA_W - k));
`else
            SH_OP_ROR: r = x >> k;
`endif
            default:   r = x;
        endcase
        return r;
    endfunction

    always_comb begin
        shifted = in_data;
        for (int b = LO; b <= HI; b++) begin
            if (in_shamt[b]) shifted = shift_by(shifted, in_op, in_sign, 1 << b);
        end
    end

    assign take = ~out_valid | nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_data  <= '0;
            out_shamt <= '0;
            out_sign  <= 1'b0;
            out_tag   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (take) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_op    <= in_op;
                out_data  <= shifted;
                out_shamt <= in_shamt;
                out_sign  <= in_sign;
                out_tag   <= in_tag;
            end
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA, ROR with SHIFTER_ROTATE_EN).
// STAGES register stages, valid/ready with backpressure, tag sideband.
module shifter_pipe
    import shifter_pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int STAGES  = 2,
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [TAG_W-1:0]   out_tag
);

    for (genvar i = 0; i < STAGES; i++) begin : g_st
        localparam int LO = grp_lo(i, SHAMT_W, STAGES);
        localparam int HI = grp_lo(i + 1, SHAMT_W, STAGES) - 1;

        logic               nxt;
        logic               take;
        logic               vi;
        logic               v;
        logic               si;
        logic               s;
        logic [1:0]         opi;
        logic [1:0]         op;
        logic [DATA_W-1:0]  di;
        logic [DATA_W-1:0]  d;
        logic [SHAMT_W-1:0] shi;
        logic [SHAMT_W-1:0] sh;
        logic [TAG_W-1:0]   ti;
        logic [TAG_W-1:0]   t;

        if (i == 0) begin : g_head
            assign vi  = in_valid;
            assign opi = in_op;
            assign di  = in_data;
            assign shi = in_shamt;
            assign si  = in_data[DATA_W-1];
            assign ti  = in_tag;
        end else begin : g_body
            assign vi  = g_st[i-1].v;
            assign opi = g_st[i-1].op;
            assign di  = g_st[i-1].d;
            assign shi = g_st[i-1].sh;
            assign si  = g_st[i-1].s;
            assign ti  = g_st[i-1].t;
        end

        // Ready ripples back from the consumer through each stage.
        if (i == STAGES - 1) begin : g_tail
            assign nxt = out_ready;
        end else begin : g_link
            assign nxt = g_st[i+1].take;
        end

        shifter_stage #(
            .DATA_W  (DATA_W),
            .SHAMT_W (SHAMT_W),
            .TAG_W   (TAG_W),
            .LO      (LO),
            .HI      (HI)
        ) u_stage (
            .clk       (clk),
            .resetn    (resetn),
            .flush     (flush),
            .nxt       (nxt),
            .take      (take),
            .in_valid  (vi),
            .in_op     (opi),
            .in_data   (di),
            .in_shamt  (shi),
            .in_sign   (si),
            .in_tag    (ti),
            .out_valid (v),
            .out_op    (op),
            .out_data  (d),
            .out_shamt (sh),
            .out_sign  (s),
            .out_tag   (t)
        );
    end

    assign in_ready  = g_st[0].take;
    assign out_valid = g_st[STAGES-1].v;
    assign out_data  = g_st[STAGES-1].d;
    assign out_tag   = g_st[STAGES-1].t;

    logic unused_tail;
    assign unused_tail = ^{g_st[STAGES-1].op, g_st[STAGES-1].sh, g_st[STAGES-1].s};

endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe: scoreboard plus per-scenario tasks.
module tb_shifter_pipe;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int STAGES  = 2;
    localparam int TAG_W   = 5;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_op = 2'b00;
    logic [DATA_W-1:0] in_data = '0;
    logic [4:0]        in_shamt = '0;
    logic [4:0]        in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        out_tag;

    shifter_pipe #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W),
        .STAGES  (STAGES),
        .TAG_W   (TAG_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;
    int n_out = 0;
    logic held_v = 1'b0;
    logic [31:0] held_d;
    logic [4:0] held_t;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                          input logic [4:0] sh);
        logic [31:0] r;
        case (op)
            2'b00: r = d << sh;
            2'b01: r = d >> sh;
            2'b10: r = 32'($signed(d) >>> sh);
`ifdef SHIFTER_ROTATE_EN
            default: r = (d >> sh) | (d << (32 - int'(sh)));
`else
            default: r = d >> sh;
`endif
        endcase
        return r;
    endfunction

    // Scoreboard: push on accept, pop on output handshake, mid-cycle sampling.
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (held_v && out_valid) begin
                n_checks++;
                if (out_data !== held_d || out_tag !== held_t) begin
                    n_fail++;
                    $display("FAIL stall_hold: data=%h tag=%0d, required data=%h tag=%0d",
                             out_data, out_tag, held_d, held_t);
                end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_t = out_tag;
            if (out_valid && out_ready) begin
                n_checks++;
                n_out++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: data=%h tag=%0d, required no output",
                             out_data, out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_tag !== e.tag) begin
                        n_fail++;
                        $display("FAIL sb_result: data=%h tag=%0d, required data=%h tag=%0d",
                                 out_data, out_tag, e.data, e.tag);
                    end
                end
            end
            if (in_valid && in_ready && !flush)
                sb.push_back('{model(in_op, in_data, in_shamt), in_tag});
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [1:0] op, input logic [31:0] d,
                           input logic [4:0] sh, input logic [4:0] tag);
        int k;
        in_op = op;
        in_data = d;
        in_shamt = sh;
        in_tag = tag;
        in_valid = 1'b1;
        k = 0;
        #1;
        while (!in_ready && k < 50) begin
            tick();
            #1;
            k++;
        end
        if (k >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || out_valid) && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        n_checks += 4;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        if (out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h, required 0", out_data);
        end
        if (out_tag !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_out_tag: got %0d, required 0", out_tag);
        end
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_sll_latency();
        int lat;
        out_ready = 1'b1;
        in_op = 2'b00;
        in_data = 32'h0000_0001;
        in_shamt = 5'd31;
        in_tag = 5'd7;
        in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sll_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_checks += 3;
        if (lat != STAGES) begin
            n_fail++;
            $display("FAIL sll_latency: got %0d cycles, required %0d", lat, STAGES);
        end
        if (out_data !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL sll_data: got %h, required 80000000", out_data);
        end
        if (out_tag !== 5'd7) begin
            n_fail++;
            $display("FAIL sll_tag: got %0d, required 7", out_tag);
        end
        wait_drain();
    endtask

    task automatic test_ops();
        logic [1:0]  ops [10] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11,
                                  2'b10, 2'b10, 2'b00, 2'b01};
        logic [31:0] dat [10] = '{32'h8000_0F00, 32'h8000_0F00, 32'hDEAD_BEEF,
                                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                                  32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001,
                                  32'h8000_0000};
        logic [4:0]  sha [10] = '{5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0,
                                  5'd31, 5'd31, 5'd8, 5'd24};
        logic [31:0] exp [10] = '{32'hF800_00F0, 32'h0800_00F0, 32'hDEAD_BEEF,
                                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                                  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0100,
                                  32'h0000_0080};
        int k;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_op(ops[i], dat[i], sha[i], 5'(i));
            k = 0;
            while (!out_valid && k < 20) begin
                tick();
                k++;
            end
            n_checks++;
            if (out_data !== exp[i]) begin
                n_fail++;
                $display("FAIL ops_%0d: got %h, required %h", i, out_data, exp[i]);
            end
            wait_drain();
        end
    endtask

    task automatic test_ror();
        int k;
        logic [31:0] want;
`ifdef SHIFTER_ROTATE_EN
        want = 32'h1000_000F;
`else
        want = 32'h0000_000F;
`endif
        out_ready = 1'b1;
        send_op(2'b11, 32'h0000_00F1, 5'd4, 5'd21);
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        n_checks++;
        if (out_data !== want || out_tag !== 5'd21) begin
            n_fail++;
            $display("FAIL ror: got %h tag %0d, required %h tag 21", out_data, out_tag, want);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op [8];
        logic [31:0] d [8];
        logic [4:0]  sh [8];
        int i;
        int c;
        int n0;
        logic acc;
        logic saw_stall;
        for (int j = 0; j < 8; j++) begin
            op[j] = 2'($urandom_range(0, 3));
            d[j] = $urandom;
            sh[j] = 5'($urandom_range(0, 31));
        end
        i = 0;
        c = 0;
        n0 = n_out;
        saw_stall = 1'b0;
        while (i < 8 && c < 200) begin
            out_ready = !(c >= 3 && c < 6);
            in_op = op[i];
            in_data = d[i];
            in_shamt = sh[i];
            in_tag = 5'(i + 8);
            in_valid = 1'b1;
            #1;
            acc = in_ready;
            if (!in_ready) saw_stall = 1'b1;
            @(posedge clk);
            #1;
            if (acc) i++;
            c++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        n_checks += 2;
        if (n_out - n0 != 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs, required 8", n_out - n0);
        end
        if (saw_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_in_ready: never dropped, required a drop when full");
        end
    endtask

    task automatic test_flush();
        int cnt;
        out_ready = 1'b0;
        send_op(2'b00, 32'h0000_0011, 5'd1, 5'd1);
        send_op(2'b01, 32'h0000_0022, 5'd1, 5'd2);
        in_op = 2'b00;
        in_data = 32'h0000_0033;
        in_shamt = 5'd0;
        in_tag = 5'd31;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_full: out_valid=%b, required 0", out_valid);
        end
        out_ready = 1'b1;
        in_data = 32'h0000_0044;
        in_tag = 5'd30;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) cnt++;
            tick();
        end
        n_checks++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL flush_leak: got %0d valid cycles, required 0", cnt);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b1;
        send_op(2'b00, 32'h0000_00FF, 5'd4, 5'd3);
        send_op(2'b01, 32'hF000_0000, 5'd4, 5'd4);
        send_op(2'b10, 32'h8000_0000, 5'd2, 5'd5);
        #2;
        resetn = 1'b0;
        #1;
        sb.delete();
        n_checks += 3;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_valid: got %b, required 0", out_valid);
        end
        if (out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_data: got %h, required 0", out_data);
        end
        if (out_tag !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_mid_tag: got %0d, required 0", out_tag);
        end
        tick();
        tick();
        #3;
        resetn = 1'b1;
        tick();
        in_op = 2'b00;
        in_data = 32'h0000_0003;
        in_shamt = 5'd1;
        in_tag = 5'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_checks += 2;
        if (lat != STAGES) begin
            n_fail++;
            $display("FAIL rst_mid_latency: got %0d, required %0d", lat, STAGES);
        end
        if (out_data !== 32'h0000_0006) begin
            n_fail++;
            $display("FAIL rst_mid_first: got %h, required 00000006", out_data);
        end
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sll_latency();
        test_ops();
        test_ror();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
